// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl: beat scheduler for the conv array, IDLE -> RUN -> DONE over kernel/channel/row/cycle counters.
// Outputs decode registered state only; `CONV_SCHED_STALL_EN lets in_stall freeze the counters and gate the beats.
module conv_sched_ctrl #(
    parameter int unsigned ROWS = 61
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_start_conv,
    input  logic [2:0] in_cfg_ci,
    input  logic [2:0] in_cfg_co,
    input  logic       in_stall,
    output logic       out_readw_ctl,
    output logic       out_readi_ctl,
    output logic       out_write_ctl,
    output logic       out_write_single,
    output logic       out_acc_clr,
    output logic       out_end_conv,
    output logic       out_busy,
    output logic [4:0] out_kernel_idx,
    output logic [4:0] out_channel_idx,
    output logic [5:0] out_row_idx,
    output logic [5:0] out_cycle_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CYC_LAST = 6'd33;
    localparam logic [5:0] RDW_LAST = 6'd1;
    localparam logic [5:0] RDI_LAST = 6'd31;
    localparam logic [5:0] WR_FIRST = 6'd3;
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    state_t     state_q;
    logic [4:0] nc_last_q;
    logic [4:0] nk_last_q;
    logic [4:0] kernel_q,  kernel_d;
    logic [4:0] channel_q, channel_d;
    logic [5:0] row_q,     row_d;
    logic [5:0] cycle_q,   cycle_d;
    logic       last_beat;
    logic       stall;
    logic       run;
    logic       beat_en;

    // Codes 4..7 saturate at 32; the stored value is the last index, not the count.
    function automatic logic [4:0] last_idx(input logic [2:0] code);
        case (code)
            3'd0:    return 5'd7;
            3'd1:    return 5'd15;
            3'd2:    return 5'd23;
            default: return 5'd31;
        endcase
    endfunction

`ifdef CONV_SCHED_STALL_EN
    assign stall = in_stall;
`else
    logic unused_stall;
    assign unused_stall = in_stall;
    assign stall        = 1'b0;
`endif

    always_comb begin
        cycle_d   = cycle_q + 6'd1;
        row_d     = row_q;
        channel_d = channel_q;
        kernel_d  = kernel_q;
        last_beat = 1'b0;
        if (cycle_q == CYC_LAST) begin
            cycle_d = '0;
            row_d   = row_q + 6'd1;
            if (row_q == ROW_LAST) begin
                row_d     = '0;
                channel_d = channel_q + 5'd1;
                if (channel_q == nc_last_q) begin
                    channel_d = '0;
                    kernel_d  = kernel_q + 5'd1;
                    last_beat = (kernel_q == nk_last_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            nc_last_q <= '0;
            nk_last_q <= '0;
            kernel_q  <= '0;
            channel_q <= '0;
            row_q     <= '0;
            cycle_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_start_conv) begin
                        nc_last_q <= last_idx(in_cfg_ci);
                        nk_last_q <= last_idx(in_cfg_co);
                        kernel_q  <= '0;
                        channel_q <= '0;
                        row_q     <= '0;
                        cycle_q   <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    // Final beat leaves the counters at their terminal values for DONE to hold.
                    if (!stall) begin
                        if (last_beat) begin
                            state_q <= DONE;
                        end else begin
                            kernel_q  <= kernel_d;
                            channel_q <= channel_d;
                            row_q     <= row_d;
                            cycle_q   <= cycle_d;
                        end
                    end
                end
                DONE: begin
                    if (!in_start_conv) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign run     = (state_q == RUN);
    assign beat_en = run & ~stall;

    assign out_readw_ctl    = beat_en & (cycle_q <= RDW_LAST);
    assign out_readi_ctl    = beat_en & (cycle_q <= RDI_LAST);
    assign out_write_ctl    = beat_en & (channel_q == nc_last_q) & (cycle_q >= WR_FIRST);
    assign out_write_single = out_write_ctl & (cycle_q == WR_FIRST);
    assign out_acc_clr      = run & (channel_q == 5'd0);
    assign out_end_conv     = (state_q == DONE);
    assign out_busy         = run;

    assign out_kernel_idx  = kernel_q;
    assign out_channel_idx = channel_q;
    assign out_row_idx     = row_q;
    assign out_cycle_idx   = cycle_q;

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Directed bench for conv_sched_ctrl, built with a 2-row schedule so whole convolutions fit in a short run.
// Expected counts come from the row/channel/kernel cadence: 34 cycles per row pass, 31 write beats per output row.
module tb_conv_sched_ctrl;

    localparam int ROWS = 2;
`ifdef CONV_SCHED_STALL_EN
    localparam int STALL_LAT = 5;
`else
    localparam int STALL_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] ci;
    logic [2:0] co;
    logic       stall;
    logic       readw, readi, write, wsingle, accclr, endconv, busy;
    logic [4:0] k_idx, ch_idx;
    logic [5:0] row_idx, cyc_idx;

    int n_vec = 0;
    int n_err = 0;
    int c_run, c_rw, c_ri, c_wr, c_ws, c_clr;
    int found, beats, span, ri, stall_left, stalled;

    always #5 clk = ~clk;

    conv_sched_ctrl #(.ROWS(ROWS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_start_conv    (start),
        .in_cfg_ci        (ci),
        .in_cfg_co        (co),
        .in_stall         (stall),
        .out_readw_ctl    (readw),
        .out_readi_ctl    (readi),
        .out_write_ctl    (write),
        .out_write_single (wsingle),
        .out_acc_clr      (accclr),
        .out_end_conv     (endconv),
        .out_busy         (busy),
        .out_kernel_idx   (k_idx),
        .out_channel_idx  (ch_idx),
        .out_row_idx      (row_idx),
        .out_cycle_idx    (cyc_idx)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Starts a convolution from IDLE and counts beats until end_conv; optionally perturbs cfg/start mid-run.
    task automatic run_conv(input logic [2:0] c_i, input logic [2:0] c_o, input bit scramble, input int limit);
        int done;
        @(negedge clk);
        ci = c_i; co = c_o; start = 1'b1;
        c_run = 0; c_rw = 0; c_ri = 0; c_wr = 0; c_ws = 0; c_clr = 0;
        done = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (endconv) begin
                done = 1;
                break;
            end
            c_run += int'(busy);
            c_rw  += int'(readw);
            c_ri  += int'(readi);
            c_wr  += int'(write);
            c_ws  += int'(wsingle);
            c_clr += int'(accclr);
            if (scramble && i == 100) begin
                ci = 3'd3; co = 3'd3; start = 1'b0;
            end
            if (scramble && i == 200) start = 1'b1;
        end
        check_val("end_conv_reached", done, 1);
    endtask

    task automatic expect_counts(input string tag, input int nc, input int nk);
        int passes;
        passes = nc * nk * ROWS;
        check_val({tag, " run_cycles"}, c_run, passes * 34);
        check_val({tag, " readw"},      c_rw,  passes * 2);
        check_val({tag, " readi"},      c_ri,  passes * 32);
        check_val({tag, " write"},      c_wr,  nk * ROWS * 31);
        check_val({tag, " wsingle"},    c_ws,  nk * ROWS);
        check_val({tag, " acc_clr"},    c_clr, nk * ROWS * 34);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; ci = 3'd0; co = 3'd0;
        #12;
        check_val("rst_ctl", 32'({readw, readi, write, wsingle, accclr, endconv, busy}), 0);
        check_val("rst_idx", 32'({k_idx, ch_idx, row_idx, cyc_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_no_start", 32'(busy), 0);

        run_conv(3'd0, 3'd0, 1'b0, 6000);
        expect_counts("ci0_co0", 8, 8);
        check_val("done_kernel",  32'(k_idx), 7);
        check_val("done_channel", 32'(ch_idx), 7);
        check_val("done_row",     32'(row_idx), ROWS - 1);
        check_val("done_cycle",   32'(cyc_idx), 33);

        repeat (4) @(negedge clk);
        check_val("done_hold_end", 32'(endconv), 1);
        check_val("done_hold_busy", 32'(busy), 0);
        check_val("done_hold_kernel", 32'(k_idx), 7);
        start = 1'b0;
        @(negedge clk);
        check_val("drop_end", 32'(endconv), 0);
        repeat (3) @(negedge clk);
        check_val("idle_after_done", 32'(busy), 0);

        run_conv(3'd0, 3'd0, 1'b1, 6000);
        expect_counts("cfg_change", 8, 8);
        start = 1'b0;
        @(negedge clk);

        run_conv(3'd7, 3'd0, 1'b0, 20000);
        expect_counts("ci7_co0", 32, 8);
        start = 1'b0;
        @(negedge clk);

        run_conv(3'd2, 3'd1, 1'b0, 30000);
        expect_counts("ci2_co1", 24, 16);
        start = 1'b0;
        @(negedge clk);

        // Abort mid-run with reset placed between clock edges.
        ci = 3'd0; co = 3'd0; start = 1'b1;
        found = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (k_idx == 5'd2 && row_idx == 6'd1 && cyc_idx == 6'd10) begin
                found = 1;
                break;
            end
        end
        check_val("reach_k2_row1", found, 1);
        #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        check_val("async_rst_ctl", 32'({readw, readi, write, wsingle, accclr, endconv, busy}), 0);
        check_val("async_rst_idx", 32'({k_idx, ch_idx, row_idx, cyc_idx}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0;
        repeat (20) begin
            @(negedge clk);
            beats += int'(readw | readi | write | busy | endconv);
        end
        check_val("post_rst_quiet", beats, 0);

        start = 1'b1;
        @(negedge clk);
        check_val("restart_busy",  32'(busy), 1);
        check_val("restart_cycle", 32'(cyc_idx), 0);
        check_val("restart_readw", 32'(readw), 1);
        check_val("restart_accclr", 32'(accclr), 1);
        start = 1'b0;

        // Stall for five clocks at cycle 10 of row 0.
        ri = int'(readi); span = 1; stall_left = 0; stalled = 0;
        for (int i = 0; i < 100; i++) begin
            if (cyc_idx == 6'd10 && stalled == 0) begin
                stall = 1'b1; stall_left = 5; stalled = 1;
            end
            @(negedge clk);
            if (row_idx == 6'd1) break;
            span++;
            ri += int'(readi);
            if (stall_left > 0) begin
`ifdef CONV_SCHED_STALL_EN
                check_val("stall_hold_cycle", 32'(cyc_idx), 10);
                check_val("stall_readi", 32'(readi), 0);
`endif
                stall_left--;
                if (stall_left == 0) stall = 1'b0;
            end
        end
        check_val("row_span", span, 34 + STALL_LAT);
        check_val("row_readi", ri, 32);

        rst_n = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
